// File: rtl/rr_arb_2x1.sv
// Two-source round-robin burst arbiter feeding a one-entry registered output stage; drives mux_2x1 sel.
// Optional ARB_FIXED_PRIO_EN pins the tie-break pointer to source 0 (fixed priority).
module rr_arb_2x1 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              sel
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sel;
    logic                r_prio;
    logic                r_out_valid;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_out_data;

    logic                w_out_free;
    logic                w_xfer;
    logic                w_xfer_last;
    logic [DATA_W-1:0]   w_xfer_data;

    // Ready is a function of state and the output stage only, never of the valids.
    always_comb begin
        w_out_free  = !r_out_valid || out_ready;
        in0_ready   = 1'b0;
        in1_ready   = 1'b0;
        w_xfer      = 1'b0;
        w_xfer_last = 1'b0;
        w_xfer_data = '0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in0_valid && in1_valid)
                    w_state_nxt = r_prio ? GNT1 : GNT0;
                else if (in0_valid)
                    w_state_nxt = GNT0;
                else if (in1_valid)
                    w_state_nxt = GNT1;
            end
            GNT0: begin
                in0_ready   = w_out_free;
                w_xfer      = in0_valid && w_out_free;
                w_xfer_last = in0_last;
                w_xfer_data = in0_data;
                if (w_xfer && in0_last)
                    w_state_nxt = IDLE;
            end
            GNT1: begin
                in1_ready   = w_out_free;
                w_xfer      = in1_valid && w_out_free;
                w_xfer_last = in1_last;
                w_xfer_data = in1_data;
                if (w_xfer && in1_last)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel       <= 1'b0;
            r_prio      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // sel only moves when a new grant is issued, so it remembers the last owner in IDLE.
            if (r_state == IDLE && w_state_nxt != IDLE)
                r_sel <= (w_state_nxt == GNT1);
            if (w_xfer && w_xfer_last) begin
`ifdef ARB_FIXED_PRIO_EN
                r_prio <= 1'b0;
`else
                r_prio <= (r_state == GNT0);
`endif
            end
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_xfer_data;
                r_out_last  <= w_xfer_last;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign sel       = r_sel;

endmodule

// File: tb/tb_rr_arb_2x1.sv
// Directed bench for rr_arb_2x1: transaction-level model compared every cycle, plus literal expectations.
module tb_rr_arb_2x1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in0_valid = 1'b0, in0_last = 1'b0;
    logic [7:0] in0_data = 8'h00;
    logic       in1_valid = 1'b0, in1_last = 1'b0;
    logic [7:0] in1_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       in0_ready, in1_ready, out_valid, out_last, sel;
    logic [7:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    rr_arb_2x1 #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_last(in0_last),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_last(in1_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sel(sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: owner (-1 = nobody), tie pointer, one held output beat.
    int         m_owner = -1;
    logic       m_sel = 1'b0, m_prio = 1'b0, m_ov = 1'b0, m_ol = 1'b0;
    logic [7:0] m_od = 8'h00;

    always @(posedge clk) begin
        int  old;
        bit  room, a0, a1;
        if (!rst_n) begin
            m_owner = -1; m_sel = 1'b0; m_prio = 1'b0;
            m_ov = 1'b0; m_od = 8'h00; m_ol = 1'b0;
        end else begin
            old  = m_owner;
            room = !m_ov || out_ready;
            a0   = (old == 0) && room && in0_valid;
            a1   = (old == 1) && room && in1_valid;
            if (a0 || a1) begin
                m_od = a0 ? in0_data : in1_data;
                m_ol = a0 ? in0_last : in1_last;
                m_ov = 1'b1;
                if (m_ol) begin
                    m_owner = -1;
`ifdef ARB_FIXED_PRIO_EN
                    m_prio = 1'b0;
`else
                    m_prio = a0;
`endif
                end
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (old == -1 && (in0_valid || in1_valid)) begin
                if (in0_valid && in1_valid) m_owner = m_prio ? 1 : 0;
                else                        m_owner = in0_valid ? 0 : 1;
                m_sel = (m_owner == 1);
            end
        end
    end

    // Per-cycle comparison and handshake logging, away from the active edge.
    logic [7:0] outq[$];
    logic       selq[$];
    always @(negedge clk) begin
        check("in0_ready", {31'd0, in0_ready}, {31'd0, (m_owner == 0) && (!m_ov || out_ready)});
        check("in1_ready", {31'd0, in1_ready}, {31'd0, (m_owner == 1) && (!m_ov || out_ready)});
        check("sel",       {31'd0, sel},       {31'd0, m_sel});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        check("out_data",  {24'd0, out_data},  {24'd0, m_od});
        check("out_last",  {31'd0, out_last},  {31'd0, m_ol});
        if (rst_n && out_valid && out_ready) outq.push_back(out_data);
        if (rst_n && ((in0_valid && in0_ready) || (in1_valid && in1_ready))) selq.push_back(sel);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_q(input string name, input logic [7:0] exp[$]);
        check({name, "_count"}, outq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < outq.size(); i++)
            check(name, {24'd0, outq[i]}, {24'd0, exp[i]});
    endtask

    initial begin
        // Reset held with both sources requesting
        in0_valid = 1'b1; in0_data = 8'h11;
        in1_valid = 1'b1; in1_data = 8'h55; in1_last = 1'b1;
        cyc(2);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sel", {31'd0, sel}, 32'd0);
        check("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
        check("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
        rst_n = 1'b1; in1_valid = 1'b0;
        cyc();
        check("post_rst_gnt0", {31'd0, in0_ready}, 32'd1);

        // Single three-beat burst from source 0
        outq.delete();
        cyc();
        check("burst_first_out", {24'd0, out_data}, 32'h11);
        in0_data = 8'h22;
        cyc();
        in0_data = 8'h33; in0_last = 1'b1;
        cyc();
        in0_valid = 1'b0;
        check("bubble_in0_ready", {31'd0, in0_ready}, 32'd0);
        check("burst_sel", {31'd0, sel}, 32'd0);
        cyc(2);
        check_q("burst_order", '{8'h11, 8'h22, 8'h33});

        // Round-robin tie with single-beat bursts
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        outq.delete(); selq.delete();
        in0_valid = 1'b1; in0_data = 8'hA0; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'hB0; in1_last = 1'b1;
        cyc(8);
        in0_valid = 1'b0; in1_valid = 1'b0;
        cyc(2);
`ifdef ARB_FIXED_PRIO_EN
        check_q("tie_order", '{8'hA0, 8'hA0, 8'hA0, 8'hA0});
        check("tie_sel_pattern", {28'd0, selq[0], selq[1], selq[2], selq[3]}, 32'b0000);
`else
        check_q("tie_order", '{8'hA0, 8'hB0, 8'hA0, 8'hB0});
        check("tie_sel_pattern", {28'd0, selq[0], selq[1], selq[2], selq[3]}, 32'b0101);
`endif

        // Output backpressure mid-burst
        outq.delete();
        in0_valid = 1'b1; in0_data = 8'h01; in0_last = 1'b0;
        cyc(2);
        in0_data = 8'h02;
        cyc();
        in0_data = 8'h03; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("bp_in0_ready", {31'd0, in0_ready}, 32'd0);
            check("bp_out_data", {24'd0, out_data}, 32'h02);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        cyc();
        in0_data = 8'h04; in0_last = 1'b1;
        cyc();
        in0_valid = 1'b0;
        cyc(3);
        check_q("bp_order", '{8'h01, 8'h02, 8'h03, 8'h04});

        // Grant hold while the owner pauses and the other source waits
        outq.delete();
        in1_valid = 1'b1; in1_data = 8'hC1; in1_last = 1'b0;
        cyc();
        check("hold_sel_granted", {31'd0, sel}, 32'd1);
        cyc();
        in1_valid = 1'b0;
        in0_valid = 1'b1; in0_data = 8'hD0; in0_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("hold_sel", {31'd0, sel}, 32'd1);
            check("hold_in0_ready", {31'd0, in0_ready}, 32'd0);
        end
        in1_valid = 1'b1; in1_data = 8'hC2; in1_last = 1'b1;
        cyc();
        in1_valid = 1'b0;
        cyc(2);
        in0_valid = 1'b0;
        cyc(2);
        check_q("hold_order", '{8'hC1, 8'hC2, 8'hD0});

        // Reset in the middle of a four-beat burst from source 1
        in1_valid = 1'b1; in1_data = 8'h41; in1_last = 1'b0;
        cyc(2);
        in1_data = 8'h42;
        cyc();
        check("mid_sel_before", {31'd0, sel}, 32'd1);
        rst_n = 1'b0; in1_data = 8'h43;
        in0_valid = 1'b1; in0_data = 8'h77; in0_last = 1'b1;
        cyc();
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sel", {31'd0, sel}, 32'd0);
        check("mid_rst_in1_ready", {31'd0, in1_ready}, 32'd0);
        rst_n = 1'b1;
        cyc();
        check("mid_rearb_in0_ready", {31'd0, in0_ready}, 32'd1);
        check("mid_rearb_in1_ready", {31'd0, in1_ready}, 32'd0);
        check("mid_rearb_sel", {31'd0, sel}, 32'd0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/rr_arb_2x1.md
Name: rr_arb_2x1

Overview:
- Two-requester round-robin arbiter with valid/ready handshakes. It sits directly upstream of mux_2x1.
- It decides which source owns the shared path and drives that mux's select line.
- It also registers the winning source's data into a one-entry output stage.
- Grants are held for whole bursts, delimited by a last flag, so beats from two sources never interleave.

Parameters:
- DATA_W, 8, width of each data path.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in0_valid  input  1  source 0 has a beat.
- in0_ready  output  1  source 0 beat accepted this cycle.
- in0_data  input  DATA_W  source 0 payload.
- in0_last  input  1  final beat of source 0 burst.
- in1_valid  input  1  source 1 has a beat.
- in1_ready  output  1  source 1 beat accepted this cycle.
- in1_data  input  DATA_W  source 1 payload.
- in1_last  input  1  final beat of source 1 burst.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the output beat.
- out_data  output  DATA_W  registered payload.
- out_last  output  1  registered last flag.
- sel  output  1  current owner: 0 = source 0, 1 = source 1. Drives mux_2x1 sel.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on rising clk.
- Reset (rst_n=0 at an edge):
  - state=IDLE, sel=0, out_valid=0, out_data=0, out_last=0.
  - Priority pointer prio=0, so source 0 is favoured first.
  - Reset mid-burst discards the held output beat and the partial burst; there is no recovery of the dropped beats.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - in0_ready=in1_ready=0.
  - If exactly one valid is high, go to that source's GNT state next cycle.
  - If both are valid, go to GNT<prio>.
  - If neither is valid, stay in IDLE.
- GNTk:
  - sel=k.
  - ink_ready = !out_valid || out_ready. The other source's ready is always 0.
- Transfer on ink_valid && ink_ready:
  - out_data <= ink_data, out_last <= ink_last, out_valid <= 1 at that edge.
  - Latency is one cycle from input acceptance to out_valid.
- Output drain: out_valid falls at an edge where out_valid && out_ready and no new beat is loaded. Simultaneous drain and load keeps out_valid=1 with the new data, giving full throughput.
- Burst end:
  - A transferred beat with last=1 sends the FSM to IDLE next cycle and sets prio <= ~k.
  - One arbitration bubble cycle per burst is required behaviour.
- Holding rules:
  - ink_valid dropping mid-burst keeps GNTk. The grant is held until a last beat transfers.
  - Input data and last are sampled only on transfer.
- sel register:
  - sel updates on the IDLE->GNT edge and holds through the burst.
  - sel is unchanged in IDLE, so it keeps the last owner.
- Backpressure: out_ready=0 with out_valid=1 forces ready=0. out_data and out_last must stay stable while held.
- No combinational path from inK_valid to inK_ready. ready depends only on state, out_valid and out_ready.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: prio is ignored and stuck at 0; source 0 always wins IDLE ties. All other behaviour is unchanged.
- Undefined (default): round-robin as above, with prio toggling to the non-served source after every completed burst.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles with both valids high -> out_valid=0, sel=0, both readys 0, state IDLE; after release, GNT0 is granted on the next edge.
- Single burst: in0 sends 3 beats 0x11, 0x22, 0x33(last) with out_ready=1 -> out_data 0x11, 0x22, 0x33 each one cycle after acceptance, then in0_ready=0 for the bubble cycle and sel=0 throughout.
- Round-robin tie: both valid, 1-beat bursts 0xA0 and 0xB0, repeated 4 times -> output order A0, B0, A0, B0 and sel toggling 0,1,0,1.
  - With ARB_FIXED_PRIO_EN the order is A0 every time while in0 stays valid.
- Backpressure: out_ready=0 for 3 cycles mid-burst -> in0_ready=0, out_data held stable; on release the next beat is accepted with no loss or duplication.
- Grant hold: in1 granted, in1_valid drops for 2 cycles while in0_valid=1 -> sel stays 1 and no in0 beat is accepted until in1's last beat transfers.
- Reset mid-burst: assert rst_n=0 after beat 2 of 4 -> out_valid=0 next edge, sel=0, and re-arbitration starts from IDLE with prio=0.
